input_state: RTL

Player-entry checker for the Simon Says datapath, and the receiving end of the colour sequence that `display_state` sends out. After the display phase finishes, it captures the player's button presses, debounces them, and compares each press against the same packed sequence. It then reports round success or failure to the top-level game FSM, and echoes each accepted press onto a colour bus for the LEDs.

---
 rtl/simon_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/input_state.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared Simon Says colour codes, sequence length and input FSM encoding
package simon_pkg;

  localparam logic [1:0] COL_RED    = 2'd0;
  localparam logic [1:0] COL_GREEN  = 2'd1;
  localparam logic [1:0] COL_BLUE   = 2'd2;
  localparam logic [1:0] COL_YELLOW = 2'd3;

  localparam int SEQ_LEN = 16;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_WAIT_PRESS,
    IN_WAIT_RELEASE,
    IN_DONE
  } input_fsm_t;

  // Only meaningful for a one-hot input; callers qualify it separately.
  function automatic logic [1:0] onehot_to_code(input logic [3:0] oh);
    case (oh)
      4'b0010: return COL_GREEN;
      4'b0100: return COL_BLUE;
      4'b1000: return COL_YELLOW;
      default: return COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer plus per-bit stable-count debounce filter
// A bit's debounced level follows the synchronized level after DEBOUNCE_CYCLES stable ticks.
module btn_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_db
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // Any return to the accepted level restarts the count, so bounces never accumulate.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_sync2[g] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2[g];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign o_db[g] = r_level;
  end

endmodule

// File: rtl/input_state.sv
// rtl/input_state.sv - Simon Says player-entry checker: debounced presses compared to the packed sequence
// Optional press timeout built when INPUT_TIMEOUT_EN is defined.
module input_state
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int TIMEOUT_CYCLES  = 30_000_000
) (
  input  logic                   clk,
  input  logic                   rst_input,
  input  logic                   en_input,
  input  logic [2*SEQ_LEN-1:0]   seq_in_input,
  input  logic [3:0]             round_ctr,
  input  logic [3:0]             btn,
  output logic [1:0]             colour_echo,
  output logic                   echo_oe,
  output logic                   complete_input,
  output logic                   fail_input,
  output logic [3:0]             entry_pos
);

  input_fsm_t r_state, w_state_nxt;
  logic [3:0] r_entry_pos, w_entry_pos_nxt;
  logic [1:0] r_code, w_code_nxt;
  logic       r_match, w_match_nxt;
  logic       r_echo_oe, w_echo_oe_nxt;
  logic       r_complete, w_complete_nxt;
  logic       r_fail, w_fail_nxt;
  logic       w_to_clr;
  logic       w_to_hit;
  logic [3:0] w_db;
  logic       w_db_onehot;
  logic [1:0] w_press_code;
  logic [1:0] w_exp_code;

  btn_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk (clk),
    .i_rst (rst_input),
    .i_raw (btn),
    .o_db  (w_db)
  );

  assign w_db_onehot  = (w_db != 4'd0) && ((w_db & (w_db - 4'd1)) == 4'd0);
  assign w_press_code = onehot_to_code(w_db);
  assign w_exp_code   = seq_in_input[{r_entry_pos, 1'b0} +: 2];

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst_input || w_to_clr) begin
      r_to_cnt <= '0;
    end else if (r_state == IN_WAIT_PRESS) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_to_hit = (r_state == IN_WAIT_PRESS) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0) ^ w_to_clr;
  assign w_to_hit         = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_entry_pos_nxt = r_entry_pos;
    w_code_nxt      = r_code;
    w_match_nxt     = r_match;
    w_echo_oe_nxt   = r_echo_oe;
    w_complete_nxt  = 1'b0;
    w_fail_nxt      = 1'b0;
    w_to_clr        = 1'b0;

    case (r_state)
      IN_IDLE: begin
        w_entry_pos_nxt = 4'd0;
        w_echo_oe_nxt   = 1'b0;
        w_code_nxt      = 2'd0;
        if (en_input) begin
          w_to_clr    = 1'b1;
          w_state_nxt = IN_WAIT_PRESS;
        end
      end
      IN_WAIT_PRESS: begin
        if (!en_input) begin
          w_entry_pos_nxt = 4'd0;
          w_echo_oe_nxt   = 1'b0;
          w_state_nxt     = IN_IDLE;
        end else if (w_db_onehot) begin
          w_code_nxt    = w_press_code;
          w_match_nxt   = (w_press_code == w_exp_code);
          w_echo_oe_nxt = 1'b1;
          w_state_nxt   = IN_WAIT_RELEASE;
        end else if (w_to_hit) begin
          w_fail_nxt  = 1'b1;
          w_state_nxt = IN_DONE;
        end
      end
      IN_WAIT_RELEASE: begin
        if (!en_input) begin
          w_entry_pos_nxt = 4'd0;
          w_echo_oe_nxt   = 1'b0;
          w_state_nxt     = IN_IDLE;
        end else if (w_db == 4'd0) begin
          w_echo_oe_nxt = 1'b0;
          if (!r_match) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = IN_DONE;
          end else if (r_entry_pos == round_ctr) begin
            w_complete_nxt = 1'b1;
            w_state_nxt    = IN_DONE;
          end else begin
            w_entry_pos_nxt = r_entry_pos + 4'd1;
            w_to_clr        = 1'b1;
            w_state_nxt     = IN_WAIT_PRESS;
          end
        end
      end
      IN_DONE: begin
        // Held here until the game FSM drops the enable, so it cannot re-arm on the same level.
        w_echo_oe_nxt = 1'b0;
        if (!en_input) begin
          w_entry_pos_nxt = 4'd0;
          w_state_nxt     = IN_IDLE;
        end
      end
      default: w_state_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_input) begin
      r_state     <= IN_IDLE;
      r_entry_pos <= 4'd0;
      r_code      <= 2'd0;
      r_match     <= 1'b0;
      r_echo_oe   <= 1'b0;
      r_complete  <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_entry_pos <= w_entry_pos_nxt;
      r_code      <= w_code_nxt;
      r_match     <= w_match_nxt;
      r_echo_oe   <= w_echo_oe_nxt;
      r_complete  <= w_complete_nxt;
      r_fail      <= w_fail_nxt;
    end
  end

  assign colour_echo    = r_echo_oe ? r_code : 2'd0;
  assign echo_oe        = r_echo_oe;
  assign complete_input = r_complete;
  assign fail_input     = r_fail;
  assign entry_pos      = r_entry_pos;

endmodule
